// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: clips incoming pixels, buffers them in a small FIFO,
// and turns each one into a linear-address memory write. Also runs a full-screen clear sweep.
module fb_pixel_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [9:0]         pix_x,
    input  logic [8:0]         pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_stall,
    output logic               busy,
    output logic               clear_done,
    output logic [15:0]        dropped_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [9:0]         r_fifo_x [FIFO_DEPTH];
    logic [8:0]         r_fifo_y [FIFO_DEPTH];
    logic [COLOR_W-1:0] r_fifo_c [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;

    logic               r_ready_en;
    logic               r_clear_pending;
    logic [COLOR_W-1:0] r_clear_color;
    logic [ADDR_W-1:0]  r_sweep;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [COLOR_W-1:0] r_data;
    logic               r_done;
    logic [15:0]        r_dropped;

    logic               w_full;
    logic               w_empty;
    logic               w_in_range;
    logic               w_accept;
    logic               w_push;
    logic               w_clip;
    logic               w_can_load;
    logic               w_pop;
    logic               w_start_clear;
    logic               w_sweep_load;
    logic               w_clear_finish;
    logic [ADDR_W-1:0]  w_pop_addr;

    assign w_full     = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_in_range = (32'(pix_x) < 32'(H_RES)) && (32'(pix_y) < 32'(V_RES));

    // r_ready_en keeps pix_ready low for the first cycle after a reset edge.
    assign pix_ready  = r_ready_en & ~w_full & ~r_clear_pending & (r_state == S_IDLE);
    assign w_accept   = pix_valid & pix_ready;
    assign w_push     = w_accept & w_in_range;
    assign w_clip     = w_accept & ~w_in_range;
    assign w_can_load = ~r_we | ~mem_stall;

    assign w_pop_addr = ADDR_W'(r_fifo_y[r_rptr]) * ADDR_W'(H_RES) + ADDR_W'(r_fifo_x[r_rptr]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pop          = 1'b0;
        w_start_clear  = 1'b0;
        w_sweep_load   = 1'b0;
        w_clear_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Queued pixels always drain before a pending clear is allowed to start.
                if (w_can_load) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else if (r_clear_pending) begin
                        w_start_clear = 1'b1;
                        w_state_next  = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (w_can_load) begin
                    if (r_we && (r_addr == LAST_ADDR)) begin
                        w_clear_finish = 1'b1;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_sweep_load = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_ready_en      <= 1'b0;
            r_clear_pending <= 1'b0;
            r_clear_color   <= '0;
            r_sweep         <= '0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_data          <= '0;
            r_done          <= 1'b0;
            r_dropped       <= '0;
        end else begin
            r_ready_en <= 1'b1;
            r_done     <= 1'b0;

            if (w_push) begin
                r_fifo_x[r_wptr] <= pix_x;
                r_fifo_y[r_wptr] <= pix_y;
                r_fifo_c[r_wptr] <= pix_color;
                r_wptr           <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);

            if (w_clip && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end

            if (clear_start && !r_clear_pending && (r_state != S_CLEAR)) begin
                r_clear_pending <= 1'b1;
            end

            // Output register: only reloads once the current write has been taken.
            if (w_pop) begin
                r_we   <= 1'b1;
                r_addr <= w_pop_addr;
                r_data <= r_fifo_c[r_rptr];
            end else if (w_start_clear) begin
                r_we          <= 1'b0;
                r_clear_color <= clear_color;
                r_sweep       <= '0;
            end else if (w_sweep_load) begin
                r_we    <= 1'b1;
                r_addr  <= r_sweep;
                r_data  <= r_clear_color;
                r_sweep <= r_sweep + ADDR_W'(1);
            end else if (w_clear_finish) begin
                r_we            <= 1'b0;
                r_clear_pending <= 1'b0;
                r_done          <= 1'b1;
            end else if (w_can_load) begin
                r_we <= 1'b0;
            end
        end
    end

    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_data    = r_data;
    assign clear_done  = r_done;
    assign dropped_cnt = r_dropped;
    assign busy        = ~w_empty | r_we | r_clear_pending | (r_state == S_CLEAR);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: a full-size instance for address/clip/stall checks
// and a small 40x30 instance so clear sequences fit in a short run.
`timescale 1ns/1ps
module tb_fb_pixel_writer;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [2:0]  color;
        logic        expWe;
        logic [18:0] expAddr;
        logic [15:0] expDropped;
    } vec_t;

    typedef struct {
        logic [10:0] addr;
        logic [2:0]  data;
    } wr_t;

    logic clk;
    logic rst;

    logic        aValid, aReady, aClearStart, aWe, aStall, aBusy, aDone;
    logic [9:0]  aX;
    logic [8:0]  aY;
    logic [2:0]  aColor, aClearColor, aData;
    logic [18:0] aAddr;
    logic [15:0] aDropped;

    logic        bValid, bReady, bClearStart, bWe, bStall, bBusy, bDone;
    logic [9:0]  bX;
    logic [8:0]  bY;
    logic [2:0]  bColor, bClearColor, bData;
    logic [10:0] bAddr;
    logic [15:0] bDropped;

    int errors = 0;
    int checks = 0;

    logic [18:0] aCapAddr [$];
    logic [2:0]  aCapData [$];
    wr_t         bExp [$];
    wr_t         bHead;
    int          bBad = 0;
    int          bDoneCnt = 0;

    vec_t vecs [9];

    fb_pixel_writer dutA (
        .clk(clk), .rst(rst),
        .pix_valid(aValid), .pix_ready(aReady),
        .pix_x(aX), .pix_y(aY), .pix_color(aColor),
        .clear_start(aClearStart), .clear_color(aClearColor),
        .mem_we(aWe), .mem_addr(aAddr), .mem_data(aData), .mem_stall(aStall),
        .busy(aBusy), .clear_done(aDone), .dropped_cnt(aDropped)
    );

    fb_pixel_writer #(.H_RES(40), .V_RES(30), .ADDR_W(11), .COLOR_W(3), .FIFO_DEPTH(4)) dutB (
        .clk(clk), .rst(rst),
        .pix_valid(bValid), .pix_ready(bReady),
        .pix_x(bX), .pix_y(bY), .pix_color(bColor),
        .clear_start(bClearStart), .clear_color(bClearColor),
        .mem_we(bWe), .mem_addr(bAddr), .mem_data(bData), .mem_stall(bStall),
        .busy(bBusy), .clear_done(bDone), .dropped_cnt(bDropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed writes are recorded mid-cycle, when we/stall are stable.
    always @(negedge clk) begin
        if (aWe === 1'b1 && aStall === 1'b0) begin
            aCapAddr.push_back(aAddr);
            aCapData.push_back(aData);
        end
        if (bWe === 1'b1 && bStall === 1'b0) begin
            if (bExp.size() == 0) begin
                bBad++;
            end else begin
                bHead = bExp.pop_front();
                if (bHead.addr !== bAddr || bHead.data !== bData) bBad++;
            end
        end
        if (bDone === 1'b1) bDoneCnt++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Single pixel into an idle dutA; write must appear exactly two cycles after accept.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        aValid = 1'b1;
        aX = v.x;
        aY = v.y;
        aColor = v.color;
        checkOutput({tag, " ready"}, 32'(aReady), 32'd1);
        cyc();
        aValid = 1'b0;
        checkOutput({tag, " we c+1"}, 32'(aWe), 32'd0);
        cyc();
        checkOutput({tag, " we c+2"}, 32'(aWe), 32'(v.expWe));
        if (v.expWe) begin
            checkOutput({tag, " addr"}, 32'(aAddr), 32'(v.expAddr));
            checkOutput({tag, " data"}, 32'(aData), 32'(v.color));
        end
        cyc();
        checkOutput({tag, " we after"}, 32'(aWe), 32'd0);
        checkOutput({tag, " busy after"}, 32'(aBusy), 32'd0);
        checkOutput({tag, " dropped"}, 32'(aDropped), 32'(v.expDropped));
    endtask

    initial begin
        int idx;
        bit acc;
        bit found;
        logic [18:0] streamAddr [4];
        wr_t w;

        vecs[0] = '{x: 10'd10,   y: 9'd20,  color: 3'd5, expWe: 1'b1, expAddr: 19'd12810,  expDropped: 16'd0};
        vecs[1] = '{x: 10'd0,    y: 9'd0,   color: 3'd1, expWe: 1'b1, expAddr: 19'd0,      expDropped: 16'd0};
        vecs[2] = '{x: 10'd639,  y: 9'd479, color: 3'd7, expWe: 1'b1, expAddr: 19'd307199, expDropped: 16'd0};
        vecs[3] = '{x: 10'd640,  y: 9'd0,   color: 3'd3, expWe: 1'b0, expAddr: 19'd0,      expDropped: 16'd1};
        vecs[4] = '{x: 10'd0,    y: 9'd480, color: 3'd3, expWe: 1'b0, expAddr: 19'd0,      expDropped: 16'd2};
        vecs[5] = '{x: 10'd3,    y: 9'd3,   color: 3'd6, expWe: 1'b1, expAddr: 19'd1923,   expDropped: 16'd2};
        vecs[6] = '{x: 10'd1023, y: 9'd511, color: 3'd2, expWe: 1'b0, expAddr: 19'd0,      expDropped: 16'd3};
        vecs[7] = '{x: 10'd639,  y: 9'd0,   color: 3'd4, expWe: 1'b1, expAddr: 19'd639,    expDropped: 16'd3};
        vecs[8] = '{x: 10'd0,    y: 9'd1,   color: 3'd0, expWe: 1'b1, expAddr: 19'd640,    expDropped: 16'd3};

        rst = 1'b1;
        aValid = 1'b0; aX = '0; aY = '0; aColor = '0; aClearStart = 1'b0; aClearColor = '0; aStall = 1'b0;
        bValid = 1'b0; bX = '0; bY = '0; bColor = '0; bClearStart = 1'b0; bClearColor = '0; bStall = 1'b0;

        repeat (3) cyc();
        checkOutput("reset ready", 32'(aReady), 32'd0);
        checkOutput("reset we", 32'(aWe), 32'd0);
        checkOutput("reset addr", 32'(aAddr), 32'd0);
        checkOutput("reset data", 32'(aData), 32'd0);
        checkOutput("reset busy", 32'(aBusy), 32'd0);
        checkOutput("reset done", 32'(aDone), 32'd0);
        checkOutput("reset dropped", 32'(aDropped), 32'd0);
        rst = 1'b0;
        cyc();
        checkOutput("ready after release", 32'(aReady), 32'd1);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

        // Back-to-back stream: one write per cycle, ready never drops.
        streamAddr[0] = 19'd0;
        streamAddr[1] = 19'd1;
        streamAddr[2] = 19'd2;
        streamAddr[3] = 19'd307199;
        for (int t = 0; t < 7; t++) begin
            if (t < 4) begin
                aValid = 1'b1;
                aX = (t == 3) ? 10'd639 : 10'(t);
                aY = (t == 3) ? 9'd479 : 9'd0;
                aColor = 3'(t + 1);
                checkOutput($sformatf("stream ready t%0d", t), 32'(aReady), 32'd1);
            end else begin
                aValid = 1'b0;
            end
            if (t >= 2 && t < 6) begin
                checkOutput($sformatf("stream we t%0d", t), 32'(aWe), 32'd1);
                checkOutput($sformatf("stream addr t%0d", t), 32'(aAddr), 32'(streamAddr[t - 2]));
                checkOutput($sformatf("stream data t%0d", t), 32'(aData), 32'(t - 1));
            end
            cyc();
        end
        checkOutput("stream we end", 32'(aWe), 32'd0);

        // Stall: output reg plus four FIFO entries fill, then backpressure.
        aCapAddr.delete();
        aCapData.delete();
        aStall = 1'b1;
        idx = 0;
        for (int t = 0; t < 12; t++) begin
            acc = 1'b0;
            if (idx < 6) begin
                aValid = 1'b1; aX = 10'(idx); aY = 9'd5; aColor = 3'(idx + 1);
                acc = aReady;
            end
            cyc();
            if (acc) idx++;
        end
        checkOutput("stall accepted", 32'(idx), 32'd5);
        checkOutput("stall ready", 32'(aReady), 32'd0);
        checkOutput("stall we", 32'(aWe), 32'd1);
        checkOutput("stall addr", 32'(aAddr), 32'd3200);
        checkOutput("stall data", 32'(aData), 32'd1);
        cyc();
        checkOutput("stall addr held", 32'(aAddr), 32'd3200);
        checkOutput("stall data held", 32'(aData), 32'd1);
        aStall = 1'b0;
        for (int t = 0; t < 20 && idx < 6; t++) begin
            aValid = 1'b1; aX = 10'(idx); aY = 9'd5; aColor = 3'(idx + 1);
            acc = aReady;
            cyc();
            if (acc) idx++;
        end
        aValid = 1'b0;
        repeat (10) cyc();
        checkOutput("stall all accepted", 32'(idx), 32'd6);
        checkOutput("stall write count", 32'(aCapAddr.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < aCapAddr.size()) begin
                checkOutput($sformatf("stall wr%0d addr", k), 32'(aCapAddr[k]), 32'(3200 + k));
                checkOutput($sformatf("stall wr%0d data", k), 32'(aCapData[k]), 32'(k + 1));
            end
        end

        // Clear on dutB: two queued pixels drain, then sweep 0..1199 with color 2.
        w.addr = 11'd41; w.data = 3'd3; bExp.push_back(w);
        w.addr = 11'd42; w.data = 3'd4; bExp.push_back(w);
        for (int a = 0; a < 1200; a++) begin
            w.addr = 11'(a); w.data = 3'd2; bExp.push_back(w);
        end
        bClearColor = 3'd2;
        bValid = 1'b1; bX = 10'd1; bY = 9'd1; bColor = 3'd3;
        cyc();
        bX = 10'd2; bColor = 3'd4;
        checkOutput("clr q2 ready", 32'(bReady), 32'd1);
        cyc();
        bValid = 1'b0;
        bClearStart = 1'b1;
        cyc();
        bClearStart = 1'b0;
        checkOutput("clr ready low", 32'(bReady), 32'd0);
        checkOutput("clr busy", 32'(bBusy), 32'd1);
        found = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            bClearStart = (t == 100);
            cyc();
            if (bDone === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        bClearStart = 1'b0;
        checkOutput("clr done seen", 32'(found), 32'd1);
        checkOutput("clr we at done", 32'(bWe), 32'd0);
        cyc();
        checkOutput("clr ready after done", 32'(bReady), 32'd1);
        checkOutput("clr busy after done", 32'(bBusy), 32'd0);
        checkOutput("clr done pulses", 32'(bDoneCnt), 32'd1);
        checkOutput("clr writes remaining", 32'(bExp.size()), 32'd0);
        checkOutput("clr bad writes", 32'(bBad), 32'd0);

        // Reset in the middle of a clear at sweep address 1000.
        for (int a = 0; a <= 1000; a++) begin
            w.addr = 11'(a); w.data = 3'd6; bExp.push_back(w);
        end
        bClearColor = 3'd6;
        bClearStart = 1'b1;
        cyc();
        bClearStart = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 1500; t++) begin
            if (bWe === 1'b1 && bAddr == 11'd1000) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        checkOutput("rst reached addr 1000", 32'(found), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checkOutput("rst ready", 32'(bReady), 32'd0);
        checkOutput("rst we", 32'(bWe), 32'd0);
        checkOutput("rst addr", 32'(bAddr), 32'd0);
        checkOutput("rst data", 32'(bData), 32'd0);
        checkOutput("rst busy", 32'(bBusy), 32'd0);
        checkOutput("rst done", 32'(bDone), 32'd0);
        checkOutput("rst dropped", 32'(bDropped), 32'd0);
        cyc();
        checkOutput("rst ready after release", 32'(bReady), 32'd1);
        repeat (20) cyc();
        checkOutput("rst no done pulse", 32'(bDoneCnt), 32'd1);
        checkOutput("rst idle busy", 32'(bBusy), 32'd0);
        checkOutput("rst writes remaining", 32'(bExp.size()), 32'd0);

        w.addr = 11'd85; w.data = 3'd7; bExp.push_back(w);
        bValid = 1'b1; bX = 10'd5; bY = 9'd2; bColor = 3'd7;
        checkOutput("post-rst ready", 32'(bReady), 32'd1);
        cyc();
        bValid = 1'b0;
        cyc();
        checkOutput("post-rst we", 32'(bWe), 32'd1);
        checkOutput("post-rst addr", 32'(bAddr), 32'd85);
        checkOutput("post-rst data", 32'(bData), 32'd7);
        cyc();
        checkOutput("post-rst writes remaining", 32'(bExp.size()), 32'd0);
        checkOutput("post-rst bad writes", 32'(bBad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
Consumer end of the pixel stream produced by the line and triangle rasterisers. It accepts (X,Y,color) pixels through a valid/ready handshake, clips off-screen pixels, buffers the rest in a small FIFO and turns each one into a framebuffer memory write at a linear address. It also provides a full-screen clear sequencer, so the drawing engine can clear the screen and then rasterise primitives through the same write port.

Parameters:
H_RES, 640, horizontal resolution in pixels
V_RES, 480, vertical resolution in pixels
ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
COLOR_W, 3, pixel color width
FIFO_DEPTH, 4, pixel FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
pix_valid  in  1  pixel present on pix_x/pix_y/pix_color
pix_ready  out  1  block can accept a pixel this cycle
pix_x  in  10  pixel column
pix_y  in  9  pixel row
pix_color  in  COLOR_W  pixel color
clear_start  in  1  one-cycle pulse requesting a full-screen clear
clear_color  in  COLOR_W  fill color; sampled when the clear begins
mem_we  out  1  framebuffer write strobe
mem_addr  out  ADDR_W  write address, equal to y*H_RES + x
mem_data  out  COLOR_W  write data
mem_stall  in  1  memory cannot take a write this cycle
busy  out  1  work is outstanding
clear_done  out  1  one-cycle pulse when a clear completes
dropped_cnt  out  16  count of clipped pixels; saturates at 16'hFFFF

Behaviour:
- Reset: with rst high at a posedge, the block flushes the FIFO, aborts any clear, and drops any pending clear. All outputs read 0 in the next cycle: pix_ready, mem_we, mem_addr, mem_data, busy, clear_done, dropped_cnt. pix_ready rises in the first cycle after rst is released. A reset in the middle of a clear never produces a clear_done pulse.
- Handshake: a pixel transfers when pix_valid & pix_ready are both high at a posedge.
- pix_ready = !fifo_full & !clear_pending & (state==IDLE). fifo_full is registered, so a push into a full FIFO is impossible.
- Clipping: a pixel with pix_x >= H_RES or pix_y >= V_RES is still accepted, but it is not stored and produces no write. dropped_cnt increments by 1 on that edge and saturates.
- States:
  - IDLE: pop the FIFO into the output register whenever the FIFO is non-empty and (!mem_we | !mem_stall).
  - CLEAR: sweep the whole screen.
- Output register: mem_we/mem_addr/mem_data hold stable while mem_we & mem_stall.
- A write completes on an edge where mem_we & !mem_stall. On that edge the next FIFO entry loads, or mem_we drops to 0 if the FIFO is empty.
- Latency: a pixel accepted at the edge ending cycle c drives mem_we=1 in cycle c+2, provided there is no stall and the FIFO was empty. Sustained throughput is 1 pixel per cycle.
- FIFO ordering is strict FIFO. A push and a pop on the same edge are both legal.
- Address arithmetic: unsigned y*H_RES + x, computed at pop and truncated to ADDR_W.
- Clear request: a clear_start pulse sets clear_pending. pix_ready drops in the next cycle.
  - Pending pixels already in the FIFO and output register drain first.
  - When the FIFO is empty and (!mem_we | !mem_stall), the block moves to CLEAR, captures clear_color, and sets the sweep counter to 0.
- CLEAR: emit writes to addresses 0 .. H_RES*V_RES-1 in increasing order, one per non-stalled cycle, with mem_data = captured color.
  - After the write to the last address completes, return to IDLE and clear clear_pending.
  - Pulse clear_done for exactly the cycle after that completing edge; mem_we is 0 in that same cycle.
- A clear_start pulse while a clear is already pending or active is ignored.
- A pixel accepted in the same cycle as a clear_start pulse is written before the clear begins.
- busy = fifo non-empty | mem_we | clear_pending | (state==CLEAR).

Test Plan:
- Accept (10,20,color 5) into the idle block with no stall → mem_we=1, mem_addr=12810, mem_data=5 exactly 2 cycles after accept; busy falls one cycle after the write completes.
- Stream pixels (0,0),(1,0),(2,0),(639,479) back-to-back with no stall → addresses 0,1,2,307199 written in order on consecutive cycles; pix_ready stays 1 throughout.
- Send (640,0) then (0,480) → no writes occur, dropped_cnt=2; a following pixel (3,3) → address 1923.
- Hold mem_stall=1 while streaming 6 pixels → pix_ready drops once 4 are buffered; mem_addr/mem_data stay stable during the stall; release mem_stall → all 6 are written in order with none lost.
- Queue 2 pixels, then pulse clear_start with clear_color=2 → the 2 pixels are written first, then addresses 0..307199 with data 2; clear_done pulses once; pix_ready returns to 1 in the cycle after clear_done.
- Assert rst midway through a clear at sweep address 1000 → all outputs read 0 in the next cycle, clear_done never pulses, and a fresh pixel after release is written normally.
